// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Sequencing FSM for a direct-mapped write-back cache (64 lines, 128-bit
// blocks). Accepts one CPU load/store at a time. It strobes the cache for a
// lookup, a word write or a block refill. It performs a dirty write-back and
// a block allocation over a req/ack memory port, and keeps saturating
// first-lookup hit/miss statistics.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   cpu_valid       : CPU request present (sampled only in IDLE)
//   cpu_req_type    : 0 = read, 1 = write (latched with the request)
//   cpu_ready       : 1-cycle pulse, request complete
//   mem_err         : 1-cycle pulse with cpu_ready, request aborted
//   hit, dirty_bit  : cache lookup result, valid the cycle after read_en_cache
//   read_en_cache   : lookup strobe
//   write_en_cache  : word write strobe, or block write together with refill
//   refill          : load the fetched block, set valid, clear dirty
//   req_type        : latched request type, forwarded to the cache
//   mem_write_req   : write the dirty block back, held until mem_ack
//   mem_read_req    : fetch a block, held until mem_ack
//   mem_ack         : 1-cycle memory completion
//   hit_count       : saturating count of first-lookup hits
//   miss_count      : saturating count of first-lookup misses
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_valid,
    input  logic             cpu_req_type,
    output logic             cpu_ready,
    output logic             mem_err,
    input  logic             hit,
    input  logic             dirty_bit,
    output logic             read_en_cache,
    output logic             write_en_cache,
    output logic             refill,
    output logic             req_type,
    output logic             mem_write_req,
    output logic             mem_read_req,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        WR_HIT,
        WBACK,
        ALLOC,
        REFILL,
        DONE
    } state_t;

    state_t            state_reg,      state_next;
    logic              req_type_reg,   req_type_next;
    logic              refilled_reg,   refilled_next;
    logic              err_reg,        err_next;
    logic [WAIT_W-1:0] wait_cnt_reg,   wait_cnt_next;
    logic [CNT_W-1:0]  hit_count_reg,  hit_count_next;
    logic [CNT_W-1:0]  miss_count_reg, miss_count_next;

    // The last cycle of the memory wait budget: no ack here means abort.
    logic wait_expired;
    assign wait_expired = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_type_reg   <= 1'b0;
            refilled_reg   <= 1'b0;
            err_reg        <= 1'b0;
            wait_cnt_reg   <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            req_type_reg   <= req_type_next;
            refilled_reg   <= refilled_next;
            err_reg        <= err_next;
            wait_cnt_reg   <= wait_cnt_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        req_type_next   = req_type_reg;
        refilled_next   = refilled_reg;
        err_next        = err_reg;
        wait_cnt_next   = wait_cnt_reg;
        hit_count_next  = hit_count_reg;
        miss_count_next = miss_count_reg;

        unique case (state_reg)
            IDLE: begin
                if (cpu_valid) begin
                    state_next    = LOOKUP;
                    req_type_next = cpu_req_type;
                    refilled_next = 1'b0;
                    err_next      = 1'b0;
                end
            end

            LOOKUP: state_next = CHECK;

            CHECK: begin
                // Only the first lookup of a request feeds the statistics;
                // the re-lookup after a refill is bookkeeping, not a hit.
                if (!refilled_reg) begin
                    if (hit) begin
                        if (hit_count_reg != {CNT_W{1'b1}})
                            hit_count_next = hit_count_reg + 1'b1;
                    end else begin
                        if (miss_count_reg != {CNT_W{1'b1}})
                            miss_count_next = miss_count_reg + 1'b1;
                    end
                end

                if (hit) begin
                    state_next = req_type_reg ? WR_HIT : DONE;
                end else if (refilled_reg) begin
                    // A miss straight after our own refill would loop forever.
                    state_next = DONE;
                    err_next   = 1'b1;
                end else if (dirty_bit) begin
                    state_next    = WBACK;
                    wait_cnt_next = '0;
                end else begin
                    state_next    = ALLOC;
                    wait_cnt_next = '0;
                end
            end

            WR_HIT: state_next = DONE;

            WBACK: begin
                if (mem_ack) begin
                    state_next    = ALLOC;
                    wait_cnt_next = '0;
                end else if (wait_expired) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            ALLOC: begin
                if (mem_ack) begin
                    state_next = REFILL;
                end else if (wait_expired) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            REFILL: begin
                refilled_next = 1'b1;
                state_next    = LOOKUP;
            end

            DONE: state_next = IDLE;

            default: state_next = IDLE;
        endcase
    end

    // Moore-decoded strobes: every output is a function of the state register
    // (plus latched flags), so nothing combinational leaks from the inputs.
    assign read_en_cache  = (state_reg == LOOKUP);
    assign write_en_cache = (state_reg == WR_HIT) || (state_reg == REFILL);
    assign refill         = (state_reg == REFILL);
    assign mem_write_req  = (state_reg == WBACK);
    assign mem_read_req   = (state_reg == ALLOC);
    assign cpu_ready      = (state_reg == DONE);
    assign mem_err        = (state_reg == DONE) && err_reg;
    assign req_type       = req_type_reg;
    assign hit_count      = hit_count_reg;
    assign miss_count     = miss_count_reg;

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Self-checking bench for cache_controller. An environment process models
// the cache array (tag/valid/dirty per line) and a memory that acks after a
// programmable delay. The stimulus process preloads a line and issues a
// request. It then pushes the expected outcome, derived from the request-level
// rules, into a scoreboard queue. A monitor pops the queue on every cpu_ready
// and compares completion cycle, error flag, counters, memory request lengths,
// protocol sanity and the resulting line state.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cpu_valid = 1'b0;
    logic             cpu_req_type = 1'b0;
    logic             hit = 1'b0;
    logic             dirty_bit = 1'b0;
    logic             mem_ack = 1'b0;
    logic             cpu_ready, mem_err, read_en_cache, write_en_cache, refill;
    logic             req_type, mem_write_req, mem_read_req;
    logic [CNT_W-1:0] hit_count, miss_count;

    cache_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_valid      (cpu_valid),
        .cpu_req_type   (cpu_req_type),
        .cpu_ready      (cpu_ready),
        .mem_err        (mem_err),
        .hit            (hit),
        .dirty_bit      (dirty_bit),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .refill         (refill),
        .req_type       (req_type),
        .mem_write_req  (mem_write_req),
        .mem_read_req   (mem_read_req),
        .mem_ack        (mem_ack),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment state: cache array and memory behaviour for the current request.
    bit         c_valid [64];
    bit         c_dirty [64];
    logic [7:0] c_tag   [64];
    int         cur_idx = 0;
    logic [7:0] cur_tag = 8'h00;
    int         wdelay = 1;
    int         rdelay = 1;
    bit         broken = 1'b0;

    // Reference model state.
    int m_hits = 0;
    int m_misses = 0;

    typedef struct {
        int         num;
        int         ready_cyc;
        int         err;
        int         hits;
        int         misses;
        int         wr_cycles;
        int         rd_cycles;
        int         idx;
        int         f_valid;
        int         f_dirty;
        int         f_tag;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int txn_num = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // ---------------- environment: cache array + memory ----------------
    initial begin : env
        int cnt;
        bit pw;
        bit pr;
        cnt = 0;
        pw  = 1'b0;
        pr  = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                cnt = 0;
                pw  = 1'b0;
                pr  = 1'b0;
            end else begin
                if (mem_write_req) begin
                    if (!pw) cnt = 0;
                    cnt++;
                    if (cnt == wdelay) mem_ack = 1'b1;
                end else if (mem_read_req) begin
                    if (!pr) cnt = 0;
                    cnt++;
                    if (cnt == rdelay) mem_ack = 1'b1;
                end else if ($urandom_range(0, 3) == 0) begin
                    // Stray acks outside a memory wait must be ignored.
                    mem_ack = 1'b1;
                end
                pw = mem_write_req;
                pr = mem_read_req;

                if (read_en_cache) begin
                    hit       = c_valid[cur_idx] && (c_tag[cur_idx] == cur_tag);
                    dirty_bit = c_dirty[cur_idx];
                end
                if (write_en_cache) begin
                    if (refill) begin
                        if (!broken) begin
                            c_valid[cur_idx] = 1'b1;
                            c_tag[cur_idx]   = cur_tag;
                            c_dirty[cur_idx] = 1'b0;
                        end
                    end else begin
                        c_dirty[cur_idx] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int   wr_c;
        int   rd_c;
        int   viol;
        exp_t e;
        wr_c = 0;
        rd_c = 0;
        viol = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wr_c = 0;
                rd_c = 0;
                viol = 0;
                continue;
            end
            if (mem_write_req) wr_c++;
            if (mem_read_req)  rd_c++;
            if (mem_write_req && mem_read_req) viol++;
            if (int'(read_en_cache) + int'(write_en_cache) > 1) viol++;
            if (refill && !write_en_cache) viol++;
            if (mem_err && !cpu_ready) viol++;
            if (cpu_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cpu_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_cycle", cyc, e.ready_cyc);
                    chk("mem_err", int'(mem_err), e.err);
                    chk("hit_count", int'(hit_count), e.hits);
                    chk("miss_count", int'(miss_count), e.misses);
                    chk("wr_req_cycles", wr_c, e.wr_cycles);
                    chk("rd_req_cycles", rd_c, e.rd_cycles);
                    chk("protocol_violations", viol, 0);
                    chk("line_valid", int'(c_valid[e.idx]), e.f_valid);
                    chk("line_dirty", int'(c_dirty[e.idx]), e.f_dirty);
                    chk("line_tag", int'(c_tag[e.idx]), e.f_tag);
                    $display("[TB] txn %0d idx %0d done at cycle %0d err=%0d hits=%0d misses=%0d wr=%0d rd=%0d",
                             e.num, e.idx, cyc, mem_err, hit_count, miss_count, wr_c, rd_c);
                end
                wr_c = 0;
                rd_c = 0;
                viol = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge while the controller is idle.
    task automatic run_txn(input int idx, input bit v, input bit d, input bit match,
                           input bit wr, input int wd, input int rd, input bit brk);
        logic [7:0] t;
        exp_t       e;
        int         lat;
        int         n;
        bit         timed;
        t = 8'($urandom);
        c_valid[idx] = v;
        c_dirty[idx] = v & d;
        c_tag[idx]   = match ? t : (t ^ 8'h5A);
        cur_idx = idx;
        cur_tag = t;
        wdelay  = wd;
        rdelay  = rd;
        broken  = brk;

        // Request-level expectation.
        e.num       = txn_num;
        e.idx       = idx;
        e.err       = 0;
        e.wr_cycles = 0;
        e.rd_cycles = 0;
        if (v && match) begin
            if (m_hits < MAXC) m_hits++;
            lat       = wr ? 4 : 3;
            e.f_valid = 1;
            e.f_dirty = int'((v & d) | wr);
            e.f_tag   = int'(t);
        end else begin
            if (m_misses < MAXC) m_misses++;
            lat       = 3;
            timed     = 1'b0;
            e.f_valid = int'(v);
            e.f_dirty = int'(v & d);
            e.f_tag   = int'(c_tag[idx]);
            if (v && d) begin
                if (wd <= TIMEOUT) begin
                    e.wr_cycles = wd;
                    lat += wd;
                end else begin
                    e.wr_cycles = TIMEOUT;
                    lat += TIMEOUT;
                    e.err = 1;
                    timed = 1'b1;
                end
            end
            if (!timed) begin
                if (rd <= TIMEOUT) begin
                    e.rd_cycles = rd;
                    lat += rd;
                    if (brk) begin
                        lat += 3;   // refill, re-lookup, then abort
                        e.err = 1;
                    end else begin
                        lat += wr ? 4 : 3;
                        e.f_valid = 1;
                        e.f_dirty = int'(wr);
                        e.f_tag   = int'(t);
                    end
                end else begin
                    e.rd_cycles = TIMEOUT;
                    lat += TIMEOUT;
                    e.err = 1;
                end
            end
        end
        e.hits      = m_hits;
        e.misses    = m_misses;
        e.ready_cyc = cyc + lat;
        sb.push_back(e);
        txn_num++;

        cpu_valid    = 1'b1;
        cpu_req_type = wr;
        @(negedge clk);
        cpu_valid    = 1'b0;
        cpu_req_type = 1'($urandom);

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cpu_ready && n < 100);
        if (!cpu_ready) begin
            chk("cpu_ready_timeout", 0, 1);
            finish_tb();
        end
        @(negedge clk);   // DONE cycle
        @(negedge clk);   // back in IDLE
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin : stim
        int n;
        for (int i = 0; i < 64; i++) begin
            c_valid[i] = 1'b0;
            c_dirty[i] = 1'b0;
            c_tag[i]   = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            int'({cpu_ready, mem_err, read_en_cache, write_en_cache, refill,
                  req_type, mem_write_req, mem_read_req}), 0);
        chk("reset_hit_count", int'(hit_count), 0);
        chk("reset_miss_count", int'(miss_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: idx, valid, dirty, match, write, wdelay, rdelay, broken
        run_txn(0, 1, 0, 1, 0, 1, 1, 0);   // read hit
        run_txn(1, 1, 0, 1, 1, 1, 1, 0);   // write hit, line becomes dirty
        run_txn(2, 1, 0, 0, 0, 1, 3, 0);   // clean read miss
        run_txn(3, 1, 1, 0, 0, 2, 4, 0);   // dirty read miss, ack on last allowed cycle
        run_txn(4, 0, 0, 0, 1, 1, 1, 0);   // clean write miss
        run_txn(5, 1, 0, 0, 0, 1, 5, 0);   // allocation timeout
        run_txn(6, 1, 1, 0, 1, 5, 1, 0);   // write-back timeout
        run_txn(7, 1, 0, 0, 0, 1, 2, 1);   // refill ineffective -> abort, no livelock

        for (int k = 0; k < 40; k++) begin
            run_txn($urandom_range(0, 7),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 1) != 0),
                    $urandom_range(1, 6),
                    $urandom_range(1, 6),
                    ($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of an allocation: abort with no cpu_ready.
        c_valid[9] = 1'b0;
        c_dirty[9] = 1'b0;
        cur_idx = 9;
        cur_tag = 8'h33;
        rdelay  = 100;
        broken  = 1'b0;
        cpu_valid    = 1'b1;
        cpu_req_type = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_read_req && n < 20);
        chk("reached_alloc", int'(mem_read_req), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_alloc_outputs",
            int'({cpu_ready, mem_err, read_en_cache, write_en_cache, refill,
                  req_type, mem_write_req, mem_read_req}), 0);
        chk("rst_alloc_hit_count", int'(hit_count), 0);
        chk("rst_alloc_miss_count", int'(miss_count), 0);
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(10, 1, 0, 1, 0, 1, 1, 0);  // read hit after reset: counters restart
        run_txn(11, 0, 0, 0, 0, 1, 2, 0);  // clean read miss after reset

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        finish_tb();
    end

endmodule
